// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants: slot-state encodings and per-boundary payload/control widths.
package pipe_pkg;

  // State is the concatenation {main.valid, skid.valid}.
  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_INVALID = 2'b01;
  localparam logic [1:0] ST_ONE     = 2'b10;
  localparam logic [1:0] ST_FULL    = 2'b11;

  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IFID_CTRL_W  = 1;
  localparam int unsigned IDEX_DATA_W  = 101;
  localparam int unsigned IDEX_CTRL_W  = 8;
  localparam int unsigned EXMEM_DATA_W = 69;
  localparam int unsigned EXMEM_CTRL_W = 5;
  localparam int unsigned MEMWB_DATA_W = 69;
  localparam int unsigned MEMWB_CTRL_W = 3;

  function automatic logic [1:0] entry_count(input logic [1:0] st);
    return {1'b0, st[1]} + {1'b0, st[0]};
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle carrying a payload and a control field.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 3
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid flag plus payload/control, with clear taking priority over load.
module pipe_slot #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    // Clear only drops the valid flag; stale payload is harmless once invalid.
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer and flush.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MEMWB_DATA_W,
  parameter int unsigned CTRL_W = MEMWB_CTRL_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  pipe_stage_buf_if.slave         in_if,
  pipe_stage_buf_if.master        out_if,
  output logic [1:0]              count
);

  logic              m_v, s_v;
  logic [DATA_W-1:0] m_data, s_data, m_din_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_din_ctrl;
  logic              m_load, m_clear, s_load, s_clear;
  logic              in_ready, push, pop;
  logic [1:0]        state;

  assign state = {m_v, s_v};

  // With a skid slot in_ready depends only on registered state, breaking the ready path.
  assign in_ready = SKID ? (rst_n & ~s_v) : (rst_n & (~m_v | out_if.ready));
  assign push     = in_if.valid & in_ready;
  assign pop      = m_v & out_if.ready;

  // Main slot refills from the skid slot first so order is preserved.
  assign m_din_data = s_v ? s_data : in_if.data;
  assign m_din_ctrl = s_v ? s_ctrl : in_if.ctrl;

  always_comb begin
    m_load  = 1'b0;
    m_clear = flush;
    s_load  = 1'b0;
    s_clear = flush;
    if (SKID) begin
      case (state)
        ST_EMPTY: m_load = push;
        ST_ONE: begin
          m_load  = push & pop;
          s_load  = push & ~pop;
          m_clear = flush | (pop & ~push);
        end
        ST_FULL: begin
          m_load  = pop;
          s_clear = flush | pop;
        end
        default: ;
      endcase
    end else begin
      m_load  = push;
      m_clear = flush | (pop & ~push);
    end
  end

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (m_load),
    .clear_i(m_clear),
    .data_i (m_din_data),
    .ctrl_i (m_din_ctrl),
    .valid_o(m_v),
    .data_o (m_data),
    .ctrl_o (m_ctrl)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
    ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (s_load),
      .clear_i(s_clear),
      .data_i (in_if.data),
      .ctrl_i (in_if.ctrl),
      .valid_o(s_v),
      .data_o (s_data),
      .ctrl_o (s_ctrl)
    );
  end else begin : g_no_skid
    assign s_v    = 1'b0;
    assign s_data = '0;
    assign s_ctrl = '0;
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = m_v;
  assign out_if.data  = m_data;
  assign out_if.ctrl  = m_v ? m_ctrl : '0;
  assign count        = entry_count(state);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (state != ST_INVALID);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid build (u_dut) and single-register build (u_dut0).
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned DW = MEMWB_DATA_W;
  localparam int unsigned CW = MEMWB_CTRL_W;

  logic       clk;
  logic       rst_n;
  logic       flush_a;
  logic       flush_b;
  logic [1:0] count_a;
  logic [1:0] count_b;
  int         checks;
  int         errors;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) a_in ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) a_out ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) b_in ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) b_out ();

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_a),
    .in_if (a_in),
    .out_if(a_out),
    .count (count_a)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_b),
    .in_if (b_in),
    .out_if(b_out),
    .count (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Order/no-loss scoreboards and stall-stability checks, sampled on the falling edge.
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic          a_stall_q, b_stall_q;
  logic [DW-1:0] a_data_q, b_data_q;
  logic [CW-1:0] a_ctrl_q, b_ctrl_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      a_stall_q = 1'b0;
    end else begin
      if (a_stall_q) begin
        checks++;
        if (a_out.data !== a_data_q || a_out.ctrl !== a_ctrl_q) begin
          errors++;
          $display("FAIL stall_stable_a: got %h/%b want %h/%b", a_out.data, a_out.ctrl,
                   a_data_q, a_ctrl_q);
        end
      end
      if (a_out.valid && a_out.ready) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL order_a: got %h want no entry", a_out.data);
        end else begin
          if (a_out.data !== q_a[0]) begin
            errors++;
            $display("FAIL order_a: got %h want %h", a_out.data, q_a[0]);
          end
          void'(q_a.pop_front());
        end
      end
      if (flush_a) q_a.delete();
      else if (a_in.valid && a_in.ready) q_a.push_back(a_in.data);
      a_stall_q = a_out.valid && !a_out.ready && !flush_a;
      a_data_q  = a_out.data;
      a_ctrl_q  = a_out.ctrl;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q_b.delete();
      b_stall_q = 1'b0;
    end else begin
      if (b_stall_q) begin
        checks++;
        if (b_out.data !== b_data_q || b_out.ctrl !== b_ctrl_q) begin
          errors++;
          $display("FAIL stall_stable_b: got %h/%b want %h/%b", b_out.data, b_out.ctrl,
                   b_data_q, b_ctrl_q);
        end
      end
      if (b_out.valid && b_out.ready) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL order_b: got %h want no entry", b_out.data);
        end else begin
          if (b_out.data !== q_b[0]) begin
            errors++;
            $display("FAIL order_b: got %h want %h", b_out.data, q_b[0]);
          end
          void'(q_b.pop_front());
        end
      end
      if (flush_b) q_b.delete();
      else if (b_in.valid && b_in.ready) q_b.push_back(b_in.data);
      b_stall_q = b_out.valid && !b_out.ready && !flush_b;
      b_data_q  = b_out.data;
      b_ctrl_q  = b_out.ctrl;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in.valid = 1'b1; a_in.data = 69'h1234; a_in.ctrl = 3'b111; a_out.ready = 1'b0;
    b_in.valid = 1'b1; b_in.data = 69'h1234; b_in.ctrl = 3'b111; b_out.ready = 1'b0;
    step();
    step();
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out.valid); end
    checks++; if (a_out.ctrl !== 3'b000) begin errors++; $display("FAIL reset_out_ctrl: got %b want 000", a_out.ctrl); end
    checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_a); end
    checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", a_in.ready); end
    checks++; if (b_in.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_b: got %b want 0", b_in.ready); end
    rst_n = 1'b1;
    a_in.valid = 1'b0;
    b_in.valid = 1'b0;
    step();
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", a_in.ready); end
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", a_out.valid); end
  endtask

  task automatic test_streaming();
    a_out.ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a_in.valid = 1'b1; a_in.data = DW'(i + 1); a_in.ctrl = CW'(i);
      end else begin
        a_in.valid = 1'b0;
      end
      step();
      if (i < 8) begin
        checks++; if (a_out.valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, a_out.valid); end
        checks++; if (a_out.data !== DW'(i + 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_out.data, DW'(i + 1)); end
        checks++; if (a_out.ctrl !== CW'(i)) begin errors++; $display("FAIL stream_ctrl[%0d]: got %b want %b", i, a_out.ctrl, CW'(i)); end
        checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count_a); end
        checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in.ready); end
      end else begin
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", a_out.valid); end
      end
    end
  endtask

  task automatic test_skid();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 'hA; a_in.ctrl = 3'b001;
    step();
    checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL skid_count_one: got %0d want 1", count_a); end
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL skid_ready_one: got %b want 1", a_in.ready); end
    a_in.data = 'hB; a_in.ctrl = 3'b010;
    step();
    a_in.valid = 1'b0;
    checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL skid_count_full: got %0d want 2", count_a); end
    checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full: got %b want 0", a_in.ready); end
    checks++; if (a_out.data !== DW'('hA)) begin errors++; $display("FAIL skid_head: got %h want a", a_out.data); end
    checks++; if (a_out.ctrl !== 3'b001) begin errors++; $display("FAIL skid_head_ctrl: got %b want 001", a_out.ctrl); end
    step();
    checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL skid_hold_count: got %0d want 2", count_a); end
    checks++; if (a_out.data !== DW'('hA)) begin errors++; $display("FAIL skid_hold_head: got %h want a", a_out.data); end
    a_out.ready = 1'b1;
    step();
    checks++; if (a_out.data !== DW'('hB)) begin errors++; $display("FAIL skid_second: got %h want b", a_out.data); end
    checks++; if (a_out.ctrl !== 3'b010) begin errors++; $display("FAIL skid_second_ctrl: got %b want 010", a_out.ctrl); end
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL skid_ready_after_pop: got %b want 1", a_in.ready); end
    checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL skid_count_after_pop: got %0d want 1", count_a); end
    step();
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL skid_empty: got %b want 0", a_out.valid); end
  endtask

  task automatic test_flush();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 'h11; a_in.ctrl = 3'b111;
    step();
    a_in.data = 'h22;
    step();
    checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL flush_fill: got %0d want 2", count_a); end
    flush_a = 1'b1; a_in.data = 'hC;
    step();
    flush_a = 1'b0; a_in.valid = 1'b0;
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid: got %b want 0", a_out.valid); end
    checks++; if (a_out.ctrl !== 3'b000) begin errors++; $display("FAIL flush_full_ctrl: got %b want 000", a_out.ctrl); end
    checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL flush_full_count: got %0d want 0", count_a); end
    a_in.valid = 1'b1; a_in.data = 'hE;
    step();
    checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL flush_one_fill: got %0d want 1", count_a); end
    flush_a = 1'b1; a_in.data = 'hC;
    #1;
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL flush_push_ready: got %b want 1", a_in.ready); end
    step();
    flush_a = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
    checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL flush_drop_count: got %0d want 0", count_a); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_c_absent[%0d]: got %b want 0", i, a_out.valid); end
    end
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 'h33;
    step();
    a_in.data = 'h44;
    step();
    a_in.valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL reset_full_count: got %0d want 0", count_a); end
    checks++; if (a_out.ctrl !== 3'b000) begin errors++; $display("FAIL reset_full_ctrl: got %b want 000", a_out.ctrl); end
    step();
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_full_valid: got %b want 0", a_out.valid); end
  endtask

  task automatic test_bubble_ctrl();
    a_out.ready = 1'b0;
    a_in.valid = 1'b0; a_in.data = 'hFF; a_in.ctrl = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_out.ctrl !== 3'b000) begin errors++; $display("FAIL bubble_ctrl[%0d]: got %b want 000", i, a_out.ctrl); end
    end
    a_in.valid = 1'b1; a_in.data = 'h5;
    step();
    a_in.valid = 1'b0;
    checks++; if (a_out.ctrl !== 3'b101) begin errors++; $display("FAIL bubble_live_ctrl: got %b want 101", a_out.ctrl); end
    a_out.ready = 1'b1;
    step();
    checks++; if (a_out.ctrl !== 3'b000) begin errors++; $display("FAIL bubble_after_pop: got %b want 000", a_out.ctrl); end
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL bubble_after_pop_valid: got %b want 0", a_out.valid); end
  endtask

  task automatic test_skid0();
    b_out.ready = 1'b0;
    b_in.valid = 1'b1; b_in.data = 'h55; b_in.ctrl = 3'b011;
    step();
    checks++; if (count_b !== 2'd1) begin errors++; $display("FAIL s0_count: got %0d want 1", count_b); end
    checks++; if (b_out.data !== DW'('h55)) begin errors++; $display("FAIL s0_data: got %h want 55", b_out.data); end
    checks++; if (b_in.ready !== 1'b0) begin errors++; $display("FAIL s0_ready_stall: got %b want 0", b_in.ready); end
    b_out.ready = 1'b1; b_in.data = 'h66; b_in.ctrl = 3'b100;
    #1;
    checks++; if (b_in.ready !== 1'b1) begin errors++; $display("FAIL s0_ready_comb: got %b want 1", b_in.ready); end
    step();
    b_in.valid = 1'b0;
    checks++; if (b_out.data !== DW'('h66)) begin errors++; $display("FAIL s0_pass_data: got %h want 66", b_out.data); end
    checks++; if (b_out.ctrl !== 3'b100) begin errors++; $display("FAIL s0_pass_ctrl: got %b want 100", b_out.ctrl); end
    checks++; if (count_b !== 2'd1) begin errors++; $display("FAIL s0_pass_count: got %0d want 1", count_b); end
    step();
    checks++; if (b_out.valid !== 1'b0) begin errors++; $display("FAIL s0_drain: got %b want 0", b_out.valid); end
    checks++; if (count_b !== 2'd0) begin errors++; $display("FAIL s0_drain_count: got %0d want 0", count_b); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_bubble_ctrl();
    test_skid0();
    step();
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL leftover_a: got %0d want 0", q_a.size()); end
    checks++; if (q_b.size() != 0) begin errors++; $display("FAIL leftover_b: got %0d want 0", q_b.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
